// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO stage: DEPTH-entry register storage, in-order replay.
// Optional zero-latency empty bypass enabled by defining HANDSHAKE_FIFO_BYPASS_EN.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CW-1:0]         count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;

  occ_e                  occ_s;
  logic                  bypass_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Occupancy decode from the registered count.
  always_comb begin
    occ_s = OCC_PARTIAL;
    if (count_r == {CW{1'b0}}) begin
      occ_s = OCC_EMPTY;
    end else if (count_r == CW'(DEPTH)) begin
      occ_s = OCC_FULL;
    end else begin
      occ_s = OCC_PARTIAL;
    end
  end

  // Handshake outputs and the storage/pointer enables.
  always_comb begin
    bypass_s   = 1'b0;
    ins_ready  = (occ_s != OCC_FULL) & rst;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
    bypass_s   = (occ_s == OCC_EMPTY) & ins_valid & rst;
`else
    bypass_s   = 1'b0;
`endif
    outs_valid = ((occ_s != OCC_EMPTY) | bypass_s) & rst;
    case (occ_s)
      OCC_PARTIAL, OCC_FULL: outs = mem_r[rd_ptr_r];
      OCC_EMPTY:             outs = bypass_s ? ins : {DATA_WIDTH{1'b0}};
      default:               outs = {DATA_WIDTH{1'b0}};
    endcase
    if (!outs_valid) begin
      outs = {DATA_WIDTH{1'b0}};
    end else begin
      outs = outs;
    end
    push_s  = ins_valid & ins_ready;
    pop_s   = outs_valid & outs_ready;
    // A bypassed token that is taken on the spot never touches storage.
    wr_en_s = push_s & ~(bypass_s & outs_ready);
    rd_en_s = pop_s & ~bypass_s;
  end

  // Pointers and occupancy counter; cleared asynchronously so reset discards all tokens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Token storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= ins;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign count = count_r;

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed-table and scoreboard bench for handshake_fifo_buffer (DEPTH=4, DATA_WIDTH=21).
module tb_handshake_fifo_buffer;

  localparam int DW = 21;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] ins = '0;
  logic          ins_valid = 1'b0;
  logic          ins_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready = 1'b0;
  logic [CW-1:0] count;

  int checks = 0;
  int failures = 0;

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_valid(outs_valid), .outs_ready(outs_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] ins;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] e_outs;
    logic          e_ov;
    logic          e_ir;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] e_outs, input logic e_ov,
                         input logic e_ir, input logic [CW-1:0] e_cnt);
    chk({tag, ".outs"}, 64'(outs), 64'(e_outs));
    chk({tag, ".outs_valid"}, 64'(outs_valid), 64'(e_ov));
    chk({tag, ".ins_ready"}, 64'(ins_ready), 64'(e_ir));
    chk({tag, ".count"}, 64'(count), 64'(e_cnt));
  endtask

  function automatic vec_t mk(input logic [DW-1:0] i, input logic iv, input logic ordy,
                              input logic [DW-1:0] eo, input logic eov, input logic eir,
                              input logic [CW-1:0] ec);
    vec_t v;
    v.ins = i; v.iv = iv; v.ordy = ordy;
    v.e_outs = eo; v.e_ov = eov; v.e_ir = eir; v.e_cnt = ec;
    return v;
  endfunction

  logic [DW-1:0] q[$];

  initial begin
    // Expectations describe outputs just before the edge that consumes the row's inputs.
    tbl.push_back(mk(21'hA, 1'b1, 1'b0, 21'h0, 1'b0, 1'b1, 3'd0));
    tbl.push_back(mk(21'hB, 1'b1, 1'b0, 21'hA, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(21'hC, 1'b1, 1'b0, 21'hA, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(21'hD, 1'b1, 1'b0, 21'hA, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(21'hE, 1'b1, 1'b0, 21'hA, 1'b1, 1'b0, 3'd4));
    tbl.push_back(mk(21'hE, 1'b1, 1'b0, 21'hA, 1'b1, 1'b0, 3'd4));
    tbl.push_back(mk(21'h0, 1'b0, 1'b1, 21'hA, 1'b1, 1'b0, 3'd4));
    tbl.push_back(mk(21'h0, 1'b0, 1'b1, 21'hB, 1'b1, 1'b1, 3'd3));
    tbl.push_back(mk(21'h0, 1'b0, 1'b1, 21'hC, 1'b1, 1'b1, 3'd2));
    tbl.push_back(mk(21'h0, 1'b0, 1'b1, 21'hD, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(21'h0, 1'b0, 1'b0, 21'h0, 1'b0, 1'b1, 3'd0));
    tbl.push_back(mk(21'd1, 1'b1, 1'b1, 21'h0, 1'b0, 1'b1, 3'd0));
    for (int k = 2; k <= 10; k++) begin
      tbl.push_back(mk(DW'(k), 1'b1, 1'b1, DW'(k - 1), 1'b1, 1'b1, 3'd1));
    end
    tbl.push_back(mk(21'h0, 1'b0, 1'b1, 21'd10, 1'b1, 1'b1, 3'd1));
    tbl.push_back(mk(21'h0, 1'b0, 1'b0, 21'h0, 1'b0, 1'b1, 3'd0));

    // Reset state while rst is held low.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_all("reset_hold", 21'h0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all("reset_release", 21'h0, 1'b0, 1'b1, 3'd0);

`ifndef HANDSHAKE_FIFO_BYPASS_EN
    foreach (tbl[n]) begin
      @(negedge clk);
      ins = tbl[n].ins; ins_valid = tbl[n].iv; outs_ready = tbl[n].ordy;
      #1;
      chk_all($sformatf("vec%0d", n), tbl[n].e_outs, tbl[n].e_ov, tbl[n].e_ir, tbl[n].e_cnt);
    end
`endif

    // Reset mid-burst: two tokens stored, then rst pulsed low between edges.
    @(negedge clk);
    ins = 21'h09BC07; ins_valid = 1'b1; outs_ready = 1'b0;
    @(negedge clk);
    ins = 21'h000001;
    @(negedge clk);
    ins_valid = 1'b0;
    #1;
    chk("midrst.pre_count", 64'(count), 64'd2);
    rst = 1'b0;
    #1;
    chk_all("midrst.async", 21'h0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_all("midrst.after", 21'h0, 1'b0, 1'b1, 3'd0);

    // Random stall scoreboard against a queue model.
    for (int c = 0; c < 500; c++) begin
      logic          e_ov, e_ir, bp, push, pop;
      logic [DW-1:0] e_o;
      @(negedge clk);
      ins        = DW'($urandom);
      ins_valid  = 1'($urandom_range(0, 1));
      outs_ready = 1'($urandom_range(0, 1));
      bp = 1'b0;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
      bp = (q.size() == 0) && ins_valid;
`endif
      e_ir = (q.size() != DP);
      e_ov = (q.size() != 0) || bp;
      e_o  = (q.size() != 0) ? q[0] : (bp ? ins : '0);
      #1;
      chk_all($sformatf("rand%0d", c), e_o, e_ov, e_ir, CW'(q.size()));
      push = ins_valid && e_ir;
      pop  = e_ov && outs_ready;
      if (!(bp && pop)) begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ins);
      end
    end

    // Return to EMPTY before the bypass checks.
    @(negedge clk);
    ins_valid = 1'b0; outs_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

`ifdef HANDSHAKE_FIFO_BYPASS_EN
    @(negedge clk);
    ins = 21'h09BC07; ins_valid = 1'b1; outs_ready = 1'b1;
    #1;
    chk_all("bypass.take", 21'h09BC07, 1'b1, 1'b1, 3'd0);
    @(negedge clk);
    ins_valid = 1'b0;
    #1;
    chk_all("bypass.after_take", 21'h0, 1'b0, 1'b1, 3'd0);
    @(negedge clk);
    ins_valid = 1'b1; outs_ready = 1'b0;
    #1;
    chk_all("bypass.stall", 21'h09BC07, 1'b1, 1'b1, 3'd0);
    @(negedge clk);
    ins_valid = 1'b0;
    #1;
    chk_all("bypass.stored", 21'h09BC07, 1'b1, 1'b1, 3'd1);
`else
    @(negedge clk);
    ins = 21'h09BC07; ins_valid = 1'b1; outs_ready = 1'b1;
    #1;
    chk_all("nobypass.empty", 21'h0, 1'b0, 1'b1, 3'd0);
    @(negedge clk);
    ins_valid = 1'b0;
    #1;
    chk_all("nobypass.stored", 21'h09BC07, 1'b1, 1'b1, 3'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_buffer.md
# handshake_fifo_buffer

Elastic FIFO stage for the dataflow handshake fabric. It sits directly downstream of constant, arithmetic and fork stages. It accepts tokens on a valid/ready input channel, stores up to DEPTH tokens, and replays them in order on a valid/ready output channel. Its purpose is to break long ready/valid combinational chains and to absorb rate mismatch between producer and consumer.

## Interface
- DATA_WIDTH, 32, token payload width in bits.
- DEPTH, 4, token capacity; power of two, ≥2.
- CW = $clog2(DEPTH+1), derived localparam; width of count.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- ins  input  DATA_WIDTH  input token payload.
- ins_valid  input  1  producer offers token.
- ins_ready  output  1  buffer accepts token this cycle.
- outs  output  DATA_WIDTH  head token payload.
- outs_valid  output  1  head token available.
- outs_ready  input  1  consumer takes token this cycle.
- count  output  CW  tokens currently stored.

## Operation
- Storage: DEPTH-entry register array.
- Pointers: write and read pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- Occupancy: count register, 0..DEPTH.
- Push = ins_valid & ins_ready; writes ins at the write pointer and advances it.
- Pop = outs_valid & outs_ready; advances the read pointer.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Occupancy states, decoded from count:
  - EMPTY (count=0)
  - PARTIAL (0<count<DEPTH)
  - FULL (count=DEPTH)
- Transitions:
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop, when count=DEPTH−1.
  - FULL→PARTIAL on pop.
  - PARTIAL→EMPTY on pop without push, when count=1.
- ins_ready = (count≠DEPTH) & rst. No combinational path from outs_ready to ins_ready.
- When FULL, ins_ready=0 even if a pop occurs in the same cycle.
- outs_valid = (count≠0), outside bypass.
- outs = storage[read pointer] when outs_valid=1, else all zeros (masked).
- Data must not be modified. Ordering is strict FIFO.
- The producer must hold ins and ins_valid stable until accepted. The buffer does not check this.
- Simultaneous push and pop in PARTIAL: both complete; count unchanged; pointers both advance.
- Simultaneous push and pop in EMPTY: covered under Configuration.
- Reset asserted (rst=0), mid-operation included:
  - Immediately clears pointers and count.
  - Forces ins_ready=0, outs_valid=0, outs=0, count=0.
  - All stored tokens are discarded.
  - Storage array contents need not be cleared.

## Timing
- Reset values: ins_ready=0 while rst=0. After deassertion: ins_ready=1, outs_valid=0, outs=0, count=0.
- Latency, macro off: a token pushed at edge N is visible on outs with outs_valid=1 after edge N (one cycle).
- Throughput: one token per cycle, sustained in PARTIAL.
- Depth-DEPTH burst with outs_ready=0: ins_ready falls to 0 right after the DEPTH-th push edge. It rises again the cycle after the first pop.
- count is registered and reflects all pushes and pops up to the last edge.
- All outputs except outs/outs_valid under bypass are functions of registers only.

## Configuration
- Macro: HANDSHAKE_FIFO_BYPASS_EN.
- Defined:
  - In EMPTY with ins_valid=1: outs_valid=1 and outs=ins combinationally (zero latency).
  - If outs_ready=1 the token passes through with no write; count stays 0.
  - If outs_ready=0 the token is written normally; count becomes 1.
  - Creates a combinational path ins_valid/ins→outs_valid/outs.
- Undefined:
  - No bypass; EMPTY always yields outs_valid=0.
  - Push and pop can never coincide in EMPTY.
  - All outputs are register-driven except the zero mask on outs.

## Test plan
- Reset mid-burst (DEPTH=4, DATA_WIDTH=21):
  - Stimulus: push 0x09BC07 and 0x000001, then pull rst low for 1 cycle between edges.
  - Required: count=0, outs_valid=0 and outs=0 immediately, with no edge needed.
  - Required: after release, ins_ready=1 on the next cycle.
- Fill and stall:
  - Stimulus: outs_ready=0; push 0xA, 0xB, 0xC, 0xD.
  - Required: count steps 1,2,3,4; ins_ready=0 after the 4th edge; a 5th offered token 0xE is not accepted.
- Drain order:
  - Stimulus: from FULL, assert outs_ready=1 for 4 cycles.
  - Required: outs sequence 0xA, 0xB, 0xC, 0xD; ins_ready=1 one cycle after the first pop; count ends at 0.
- Streaming with pointer wrap:
  - Stimulus: ins_valid and outs_ready held at 1 for 10 tokens 1..10.
  - Required, macro off: outs yields 1..10 in order, each one cycle after its push; count holds at 1 in steady state.
- Random stall, 500 cycles:
  - Stimulus: random ins_valid/outs_ready.
  - Required: scoreboard shows no loss, duplication or reordering; count always equals pushes − pops, within 0..4.
- Bypass, macro defined:
  - Stimulus: EMPTY, ins=0x09BC07, ins_valid=1, outs_ready=1.
  - Required: same-cycle outs=0x09BC07 and outs_valid=1; count stays 0.
  - Stimulus repeated with outs_ready=0.
  - Required: count=1 after the edge.
